cpu_control: RTL and testbench
==============================

// Module: cpu_control
// PURPOSE
// - Microcode sequencer (Moore FSM) of the 8-bit CPU. Decodes the instruction register into an
//   opcode class and steps through per-instruction micro-states.
// - Emits register-file and PC strobes. cpu decodes all other strobes from the state code.
// - Runs on the fast system clock; advances one micro-state per 3-clk machine cycle.
// PARAMETERS
// - PHASES       3      clk edges per micro-state (matches cpu 100->010->001 cycle generator)
// - CYCLE_MAX    15     saturation value of the cycle output
// PORTS
// - clk           in   1  system clock; all state changes on its rising edge
// - reset_cycle   in   1  synchronous, active-high reset
// - instruction   in   8  instruction register contents
// - bus_ready     in   1  1 = memory is driving valid data on the shared bus
// - jump_allowed  in   1  condition of the current JMP is true (decoded in cpu)
// - state         out  8  current micro-state code
// - cycle         out  4  micro-step index within the current instruction
// - opcode        out  8  decoded opcode class (combinational from instruction)
// - c_rfi         out  1  register-file write enable
// - c_rfo         out  1  register-file bus-output enable
// - pc_inc        out  1  PC increment
// - pc_load       out  1  PC load from bus
// - pc_dec        out  1  PC decrement
// BEHAVIOUR
// - Reset (sync): state=NEXT(00), cycle=0, phase=0; every strobe output = 0.
// - phase counts 0,1,2,0... on clk. State/cycle update only on the edge where phase==2.
// - cycle: 0 in NEXT, +1 per state change, saturates at 15.
// - opcode decode:
//   - ir[7:6]=01 -> 40 (ALU); 10 -> 80 (MOV); 11 -> 00 (NOP).
//   - ir[7:6]=00 and ir[5:3]=000 -> ir[2:0]: 0 NOP, 1 CALL, 2 RET, 3 OUT, 4 IN, 5 HLT, 6 CMP, 7 -> NOP.
//   - ir[7:6]=00 and ir[5:3]!=000 -> {2'b00, ir[5:3], 3'b000}: 10 LDI, 18 JMP, 20 PUSH, 28 POP;
//     30/38 -> NOP.
// - State codes (hex):
//   - 00 NEXT, 01 FETCH_PC, 02 FETCH_INST, 03 HALT, 04 JUMP, 05 OUT, 07 ALU_EXEC, 08 MOV_STORE
//   - 09 MOV_FETCH, 0A MOV_LOAD, 0C FETCH_SP, 0D PC_STORE, 0E TMP_JUMP, 0F RET, 10 INC_SP
//   - 12 IN, 13 REG_STORE, 14 SET_REG, 15 LOAD_IMM, 17 ALU_WRITEBACK
// - Common prefix: NEXT->FETCH_PC->FETCH_INST->(opcode-specific sequence). After FETCH_INST:
//   - NOP: ->NEXT. HLT: ->HALT; held until reset.
//   - LDI: FETCH_PC->LOAD_IMM->SET_REG->NEXT. JMP: FETCH_PC->JUMP->NEXT.
//   - ALU: ALU_EXEC->ALU_WRITEBACK->NEXT. CMP: ALU_EXEC->NEXT.
//   - OUT: OUT->NEXT. IN: IN->NEXT. MOV: MOV_FETCH->MOV_LOAD->MOV_STORE->NEXT.
//   - PUSH: FETCH_SP->REG_STORE->NEXT. POP: INC_SP->FETCH_SP->SET_REG->NEXT.
//   - CALL: FETCH_PC->LOAD_IMM->FETCH_SP->PC_STORE->TMP_JUMP->NEXT.
//   - RET: INC_SP->FETCH_SP->RET->NEXT.
// - Strobes are combinational from state/instruction:
//   - pc_inc = FETCH_PC.
//   - pc_load = (JUMP & jump_allowed) | RET | TMP_JUMP.
//   - c_rfi = SET_REG | ALU_WRITEBACK | IN | (LOAD_IMM & CALL) | (MOV_STORE & ir[5:3]!=7).
//   - c_rfo = OUT | REG_STORE | TMP_JUMP | (MOV_STORE & ir[2:0]!=7).
//   - pc_dec = 0 (reserved; driven low).
// - Decode uses instruction at the FETCH_INST exit edge. IR must be loaded within that state.
// - Reset mid-instruction: abort; NEXT on the next clk edge regardless of phase.
// CONFIGURATION
// - CPU_CTRL_BUS_WAIT_EN defined: FETCH_INST, LOAD_IMM, JUMP, RET and MOV_LOAD hold (no state or
//   cycle change) while bus_ready==0. They advance at the first phase-2 edge with bus_ready==1.
// - Undefined: bus_ready is ignored; every state lasts exactly 3 clk.
// TESTING
// - Reset high 2 clk -> state=00, cycle=0, all strobes 0. Release -> state 01 after 3 clk.
// - instruction=8'h05 (HLT) -> 00,01,02,03; state stays 03 for 30 clk; reset -> 00.
// - instruction=8'h12 (LDI r2) -> opcode=10; states 01,02,01,15,14,00.
//   pc_inc high in both 01 states; c_rfi high in 14.
// - instruction=8'h18, jump_allowed=0 -> JUMP with pc_load=0. Repeat with 1 -> pc_load=1 for 3 clk.
// - instruction=8'h4A (ALU INC) -> opcode=40; states 07,17; c_rfi=1 in 17; cycle reaches 4.
// - WAIT_EN: bus_ready=0 in FETCH_INST for 9 clk -> state stays 02; bus_ready=1 -> advances.

Source files
------------

// File: rtl/cpu_control_if.sv
// rtl/cpu_control_if.sv - sequencer <-> datapath signal bundle
// master: cpu_control (drives state, cycle, opcode, strobes)
// slave : cpu datapath (drives instruction, bus_ready, jump_allowed)
interface cpu_control_if;
    logic [7:0] instruction;
    logic       bus_ready;
    logic       jump_allowed;
    logic [7:0] state;
    logic [3:0] cycle;
    logic [7:0] opcode;
    logic       c_rfi;
    logic       c_rfo;
    logic       pc_inc;
    logic       pc_load;
    logic       pc_dec;

    modport master (
        input  instruction, bus_ready, jump_allowed,
        output state, cycle, opcode, c_rfi, c_rfo, pc_inc, pc_load, pc_dec
    );

    modport slave (
        output instruction, bus_ready, jump_allowed,
        input  state, cycle, opcode, c_rfi, c_rfo, pc_inc, pc_load, pc_dec
    );
endinterface

// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - microcode sequencer (Moore FSM) of the 8-bit CPU
// Ports: clk (system clock), reset_cycle (sync, active-high),
//        bus (cpu_control_if.master: instruction/bus_ready/jump_allowed in;
//             state/cycle/opcode/c_rfi/c_rfo/pc_inc/pc_load/pc_dec out)
// Optional feature: CPU_CTRL_BUS_WAIT_EN - bus-access states stall while bus_ready==0.
module cpu_control #(
    parameter int unsigned PHASES    = 3,
    parameter int unsigned CYCLE_MAX = 15
) (
    input  logic                 clk,
    input  logic                 reset_cycle,
    cpu_control_if.master        bus
);

    typedef enum logic [7:0] {
        S_NEXT       = 8'h00, S_FETCH_PC  = 8'h01, S_FETCH_INST = 8'h02, S_HALT     = 8'h03,
        S_JUMP       = 8'h04, S_OUT       = 8'h05, S_ALU_EXEC   = 8'h07, S_MOV_STORE = 8'h08,
        S_MOV_FETCH  = 8'h09, S_MOV_LOAD  = 8'h0A, S_FETCH_SP   = 8'h0C, S_PC_STORE = 8'h0D,
        S_TMP_JUMP   = 8'h0E, S_RET       = 8'h0F, S_INC_SP     = 8'h10, S_IN       = 8'h12,
        S_REG_STORE  = 8'h13, S_SET_REG   = 8'h14, S_LOAD_IMM   = 8'h15, S_ALU_WB   = 8'h17
    } state_e;

    localparam logic [7:0] OP_NOP  = 8'h00, OP_CALL = 8'h01, OP_RET  = 8'h02, OP_OUT = 8'h03,
                           OP_IN   = 8'h04, OP_HLT  = 8'h05, OP_CMP  = 8'h06, OP_LDI = 8'h10,
                           OP_JMP  = 8'h18, OP_PUSH = 8'h20, OP_POP  = 8'h28, OP_ALU = 8'h40,
                           OP_MOV  = 8'h80;

    state_e     state_q, state_d, state_nxt;
    logic [3:0] cycle_q, cycle_d;
    logic [1:0] phase_q, phase_d;
    logic [7:0] op_q, op_d;     // opcode class captured when leaving FETCH_INST
    logic [7:0] opcode;
    logic       wait_hold;
    logic [7:0] ir;

    assign ir = bus.instruction;

    always_comb begin
        opcode = OP_NOP;
        case (ir[7:6])
            2'b01:   opcode = OP_ALU;
            2'b10:   opcode = OP_MOV;
            2'b11:   opcode = OP_NOP;
            default: begin
                if (ir[5:3] == 3'b000) begin
                    if (ir[2:0] != 3'd7) opcode = {5'b00000, ir[2:0]};
                end else if (ir[5:4] != 2'b11) begin
                    opcode = {2'b00, ir[5:3], 3'b000};
                end
            end
        endcase
    end

`ifdef CPU_CTRL_BUS_WAIT_EN
    assign wait_hold = !bus.bus_ready &&
                       (state_q inside {S_FETCH_INST, S_LOAD_IMM, S_JUMP, S_RET, S_MOV_LOAD});
`else
    wire unused_bus_ready = bus.bus_ready;
    assign wait_hold = 1'b0;
`endif

    always_comb begin
        state_nxt = S_NEXT;
        case (state_q)
            S_NEXT:       state_nxt = S_FETCH_PC;
            // cycle 1 means this FETCH_PC is the instruction fetch prefix,
            // otherwise it is the operand fetch of LDI/JMP/CALL.
            S_FETCH_PC: begin
                if (cycle_q == 4'd1)                      state_nxt = S_FETCH_INST;
                else if (op_q == OP_LDI || op_q == OP_CALL) state_nxt = S_LOAD_IMM;
                else if (op_q == OP_JMP)                  state_nxt = S_JUMP;
                else                                      state_nxt = S_NEXT;
            end
            S_FETCH_INST: begin
                case (opcode)
                    OP_HLT:                  state_nxt = S_HALT;
                    OP_LDI, OP_JMP, OP_CALL: state_nxt = S_FETCH_PC;
                    OP_ALU, OP_CMP:          state_nxt = S_ALU_EXEC;
                    OP_OUT:                  state_nxt = S_OUT;
                    OP_IN:                   state_nxt = S_IN;
                    OP_MOV:                  state_nxt = S_MOV_FETCH;
                    OP_PUSH:                 state_nxt = S_FETCH_SP;
                    OP_POP, OP_RET:          state_nxt = S_INC_SP;
                    default:                 state_nxt = S_NEXT;
                endcase
            end
            S_HALT:       state_nxt = S_HALT;
            S_LOAD_IMM:   state_nxt = (op_q == OP_CALL) ? S_FETCH_SP : S_SET_REG;
            S_ALU_EXEC:   state_nxt = (op_q == OP_ALU) ? S_ALU_WB : S_NEXT;
            S_MOV_FETCH:  state_nxt = S_MOV_LOAD;
            S_MOV_LOAD:   state_nxt = S_MOV_STORE;
            S_INC_SP:     state_nxt = S_FETCH_SP;
            S_PC_STORE:   state_nxt = S_TMP_JUMP;
            S_FETCH_SP: begin
                case (op_q)
                    OP_PUSH: state_nxt = S_REG_STORE;
                    OP_POP:  state_nxt = S_SET_REG;
                    OP_CALL: state_nxt = S_PC_STORE;
                    OP_RET:  state_nxt = S_RET;
                    default: state_nxt = S_NEXT;
                endcase
            end
            default:      state_nxt = S_NEXT;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        op_d    = op_q;
        phase_d = (phase_q == 2'(PHASES - 1)) ? 2'd0 : phase_q + 2'd1;
        if (phase_q == 2'(PHASES - 1) && !wait_hold) begin
            state_d = state_nxt;
            if (state_q == S_FETCH_INST) op_d = opcode;
            if (state_nxt == S_NEXT)
                cycle_d = 4'd0;
            else if (state_nxt != state_q && cycle_q != 4'(CYCLE_MAX))
                cycle_d = cycle_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_cycle) begin
            state_q <= S_NEXT;
            cycle_q <= 4'd0;
            phase_q <= 2'd0;
            op_q    <= OP_NOP;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            phase_q <= phase_d;
            op_q    <= op_d;
        end
    end

    assign bus.state   = state_q;
    assign bus.cycle   = cycle_q;
    assign bus.opcode  = opcode;
    assign bus.pc_inc  = (state_q == S_FETCH_PC);
    assign bus.pc_load = ((state_q == S_JUMP) && bus.jump_allowed) ||
                         (state_q == S_RET) || (state_q == S_TMP_JUMP);
    assign bus.c_rfi   = (state_q == S_SET_REG) || (state_q == S_ALU_WB) || (state_q == S_IN) ||
                         ((state_q == S_LOAD_IMM) && (opcode == OP_CALL)) ||
                         ((state_q == S_MOV_STORE) && (ir[5:3] != 3'd7));
    assign bus.c_rfo   = (state_q == S_OUT) || (state_q == S_REG_STORE) || (state_q == S_TMP_JUMP) ||
                         ((state_q == S_MOV_STORE) && (ir[2:0] != 3'd7));
    assign bus.pc_dec  = 1'b0;

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - self-checking bench for cpu_control
module tb_cpu_control;

    typedef logic [7:0] seq_t[$];

    logic clk = 1'b0;
    logic reset_cycle;
    int   checks = 0;
    int   errors = 0;

    cpu_control_if bus();

    cpu_control dut (
        .clk         (clk),
        .reset_cycle (reset_cycle),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Opcode class from the instruction fields, using plain arithmetic.
    function automatic logic [7:0] ref_class(input logic [7:0] ir);
        int v, top, mid, low;
        v   = int'(ir);
        top = v / 64;
        mid = (v / 8) % 8;
        low = v % 8;
        if (top == 1) return 8'h40;
        if (top == 2) return 8'h80;
        if (top == 3) return 8'h00;
        if (mid == 0) return (low == 7) ? 8'h00 : 8'(low);
        if (mid >= 6) return 8'h00;
        return 8'(mid * 8);
    endfunction

    // Full micro-state list of one instruction, starting and ending in NEXT.
    function automatic seq_t ref_seq(input logic [7:0] cls);
        seq_t q;
        case (cls)
            8'h01:   q = '{8'h00, 8'h01, 8'h02, 8'h01, 8'h15, 8'h0C, 8'h0D, 8'h0E, 8'h00};
            8'h02:   q = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h0C, 8'h0F, 8'h00};
            8'h03:   q = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h00};
            8'h04:   q = '{8'h00, 8'h01, 8'h02, 8'h12, 8'h00};
            8'h05:   q = '{8'h00, 8'h01, 8'h02, 8'h03};
            8'h06:   q = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h00};
            8'h10:   q = '{8'h00, 8'h01, 8'h02, 8'h01, 8'h15, 8'h14, 8'h00};
            8'h18:   q = '{8'h00, 8'h01, 8'h02, 8'h01, 8'h04, 8'h00};
            8'h20:   q = '{8'h00, 8'h01, 8'h02, 8'h0C, 8'h13, 8'h00};
            8'h28:   q = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h0C, 8'h14, 8'h00};
            8'h40:   q = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h17, 8'h00};
            8'h80:   q = '{8'h00, 8'h01, 8'h02, 8'h09, 8'h0A, 8'h08, 8'h00};
            default: q = '{8'h00, 8'h01, 8'h02, 8'h00};
        endcase
        return q;
    endfunction

    // {c_rfi, c_rfo, pc_inc, pc_load, pc_dec}
    function automatic logic [4:0] ref_strobes(input logic [7:0] st, input logic [7:0] cls,
                                               input logic [7:0] ir, input logic ja);
        logic rfi, rfo, inc, ld;
        int   v;
        v   = int'(ir);
        inc = (st == 8'h01);
        ld  = ((st == 8'h04) && ja) || (st == 8'h0F) || (st == 8'h0E);
        rfi = (st == 8'h14) || (st == 8'h17) || (st == 8'h12) ||
              ((st == 8'h15) && (cls == 8'h01)) || ((st == 8'h08) && ((v / 8) % 8 != 7));
        rfo = (st == 8'h05) || (st == 8'h13) || (st == 8'h0E) || ((st == 8'h08) && (v % 8 != 7));
        return {rfi, rfo, inc, ld, 1'b0};
    endfunction

    task automatic check_point(input string tag, input logic [7:0] st, input int cyc,
                               input logic [7:0] ir, input logic ja);
        logic [7:0] cls;
        cls = ref_class(ir);
        chk({tag, " state"},  32'(bus.state),  32'(st));
        chk({tag, " cycle"},  32'(bus.cycle),  32'(cyc));
        chk({tag, " opcode"}, 32'(bus.opcode), 32'(cls));
        chk({tag, " strobes"},
            32'({bus.c_rfi, bus.c_rfo, bus.pc_inc, bus.pc_load, bus.pc_dec}),
            32'(ref_strobes(st, cls, ir, ja)));
    endtask

    // Runs one instruction from NEXT (phase 0) back to NEXT (phase 0).
    task automatic run_instr(input logic [7:0] ir, input logic ja);
        seq_t       q;
        logic [7:0] cls;
        cls = ref_class(ir);
        q   = ref_seq(cls);
        bus.instruction  = ir;
        bus.jump_allowed = ja;
        if (cls == 8'h05) begin
            for (int i = 0; i < 3; i++)
                for (int p = 0; p < 3; p++) begin
                    check_point($sformatf("ir%02h s%0d p%0d", ir, i, p), q[i], i, ir, ja);
                    step();
                end
            // HALT is sticky; 31 clocks leaves phase mid-count before the reset.
            for (int k = 0; k < 31; k++) begin
                check_point($sformatf("ir%02h halt k%0d", ir, k), 8'h03, 3, ir, ja);
                step();
            end
            reset_cycle = 1'b1;
            step();
            reset_cycle = 1'b0;
            check_point($sformatf("ir%02h reset", ir), 8'h00, 0, ir, ja);
        end else begin
            for (int i = 0; i < q.size() - 1; i++)
                for (int p = 0; p < 3; p++) begin
                    check_point($sformatf("ir%02h ja%0d s%0d p%0d", ir, ja, i, p), q[i], i, ir, ja);
                    step();
                end
        end
    endtask

    initial begin
        bus.instruction  = 8'h00;
        bus.jump_allowed = 1'b0;
        bus.bus_ready    = 1'b1;
        reset_cycle      = 1'b1;
        step();
        step();
        check_point("reset", 8'h00, 0, 8'h00, 1'b0);
        reset_cycle = 1'b0;

        run_instr(8'h05, 1'b0);
        run_instr(8'h12, 1'b0);
        run_instr(8'h18, 1'b0);
        run_instr(8'h18, 1'b1);
        run_instr(8'h4A, 1'b0);
        run_instr(8'h01, 1'b1);
        run_instr(8'h02, 1'b1);
        run_instr(8'h03, 1'b0);
        run_instr(8'h04, 1'b0);
        run_instr(8'h06, 1'b0);
        run_instr(8'h07, 1'b0);
        run_instr(8'h23, 1'b0);
        run_instr(8'h2D, 1'b0);
        run_instr(8'h31, 1'b0);
        run_instr(8'h9A, 1'b0);
        run_instr(8'hBF, 1'b0);
        run_instr(8'hB8, 1'b0);
        run_instr(8'hC7, 1'b0);

        for (int n = 0; n < 40; n++)
            run_instr(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

`ifdef CPU_CTRL_BUS_WAIT_EN
        bus.instruction = 8'h00;
        repeat (6) step();
        bus.bus_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("wait k%0d state", k), 32'(bus.state), 32'h02);
            step();
        end
        bus.bus_ready = 1'b1;
        step();
        step();
        chk("wait release state", 32'(bus.state), 32'h02);
        step();
        chk("wait advance state", 32'(bus.state), 32'h00);
        chk("wait advance cycle", 32'(bus.cycle), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
